// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side engine for a synchronous FIFO with a 1-cycle registered read
// port. Pops words and presents them as a valid/ready stream framed into
// fixed-length packets. A 2-entry output buffer absorbs the read latency so
// the stream sustains one word per cycle under continuous out_ready.
//
// Optional feature macro: FIFO_READER_PARITY_EN
//   defined   -> adds output out_parity (even parity of out_data, stored with
//                the buffered word, valid together with out_valid)
//   undefined -> port and logic absent
//
// Ports
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   en          in   1           enable fetching; sampled every cycle
//   fifo_read   out  1           pop request to the FIFO read port
//   fifo_data   in   DATA_WIDTH  FIFO data_out, valid the cycle after a pop
//   fifo_empty  in   1           FIFO empty flag
//   out_valid   out  1           out_data / out_last valid
//   out_ready   in   1           consumer accepts when out_valid && out_ready
//   out_data    out  DATA_WIDTH  stream word (head of output buffer)
//   out_last    out  1           last word of a packet
//   out_parity  out  1           ^out_data (FIFO_READER_PARITY_EN only)
//   pkt_count   out  CNT_WIDTH   completed packets, wraps
//   busy        out  1           fetching, or a word buffered / in flight
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  pkt_count,
`ifdef FIFO_READER_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  busy
);

    localparam int PW = $clog2(PKT_LEN);
    localparam logic [PW-1:0] LAST_IDX = PW'(PKT_LEN - 1);

`ifdef FIFO_READER_PARITY_EN
    localparam int BUF_W = DATA_WIDTH + 1;
`else
    localparam int BUF_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BUF_W-1:0]     r_buf [0:1];   // entry 0 is the stream head
    logic [1:0]           r_buf_cnt;
    logic                 r_rd_pending;  // a pop was issued last cycle
    logic [PW-1:0]        r_fetch_cnt;
    logic [PW-1:0]        r_word_cnt;
    logic [CNT_WIDTH-1:0] r_pkt_count;

    logic                 w_pop;
    logic                 w_fetching;
    logic [2:0]           w_occupancy;
    logic                 w_fifo_read;
    logic                 w_fetch_wrap;
    logic [PW-1:0]        w_fetch_cnt_next;
    logic [BUF_W-1:0]     w_fifo_word;

`ifdef FIFO_READER_PARITY_EN
    assign w_fifo_word = {^fifo_data, fifo_data};
`else
    assign w_fifo_word = fifo_data;
`endif

    assign w_pop      = out_valid && out_ready;
    assign w_fetching = (r_state == RUN) || (r_state == FINISH);

    // Words already owned (buffered + in flight) after this cycle's pop. A
    // new read is only allowed if it still fits, so the buffer never
    // overflows. w_pop implies r_buf_cnt >= 1, so this never underflows.
    assign w_occupancy = {1'b0, r_buf_cnt} + {2'b00, r_rd_pending} - {2'b00, w_pop};
    assign w_fifo_read = w_fetching && !fifo_empty && (w_occupancy < 3'd2);

    assign w_fetch_wrap     = (r_fetch_cnt == LAST_IDX);
    assign w_fetch_cnt_next = !w_fifo_read ? r_fetch_cnt :
                              (w_fetch_wrap ? '0 : r_fetch_cnt + 1'b1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_next = RUN;
            end
            RUN: begin
                // Use the post-read fetch count: a read issued on the very
                // cycle en drops at a packet boundary opens a new packet,
                // which must then be completed in FINISH.
                if (!en) w_state_next = (w_fetch_cnt_next == '0) ? IDLE : FINISH;
            end
            FINISH: begin
                if (en)                              w_state_next = RUN;
                else if (w_fifo_read && w_fetch_wrap) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd_pending <= 1'b0;
            r_fetch_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rd_pending <= w_fifo_read;
            r_fetch_cnt  <= w_fetch_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output buffer (shift toward entry 0 on pop)
    // ------------------------------------------------------------------
    // NOTE: the buffer storage is reset because out_data is required to read
    // 0 out of reset; it is only two entries wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_buf_cnt <= 2'd0;
        end else begin
            case ({r_rd_pending, w_pop})
                2'b10: begin
                    // Capture only; occupancy guard keeps r_buf_cnt <= 1 here.
                    if (r_buf_cnt == 2'd0) r_buf[0] <= w_fifo_word;
                    else                   r_buf[1] <= w_fifo_word;
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf[0]  <= r_buf[1];
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: count unchanged.
                    if (r_buf_cnt == 2'd2) begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= w_fifo_word;
                    end else begin
                        r_buf[0] <= w_fifo_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt  <= '0;
            r_pkt_count <= '0;
        end else if (w_pop) begin
            if (r_word_cnt == LAST_IDX) begin
                r_word_cnt  <= '0;
                r_pkt_count <= r_pkt_count + 1'b1;
            end else begin
                r_word_cnt  <= r_word_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fifo_read = w_fifo_read;
    assign out_valid = (r_buf_cnt != 2'd0);
    assign out_data  = r_buf[0][DATA_WIDTH-1:0];
    // Qualified with out_valid so a packet stalled on an empty FIFO just
    // before its last word does not show a stray out_last.
    assign out_last  = out_valid && (r_word_cnt == LAST_IDX);
    assign pkt_count = r_pkt_count;
    assign busy      = (r_state != IDLE) || (r_buf_cnt != 2'd0) || r_rd_pending;
`ifdef FIFO_READER_PARITY_EN
    assign out_parity = r_buf[0][DATA_WIDTH];
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. A behavioural FIFO with a
// 1-cycle registered read port feeds the DUT; every word written that the
// stream is meant to deliver is pushed to an expected queue together with its
// expected out_last (and parity when FIFO_READER_PARITY_EN is defined), and
// popped/compared on each output handshake.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int PL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_read;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] pkt_count;
    logic          busy;
`ifdef FIFO_READER_PARITY_EN
    logic          out_parity;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .PKT_LEN   (PL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_read (fifo_read),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pkt_count (pkt_count),
`ifdef FIFO_READER_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Behavioural FIFO: written by the stimulus tasks, popped by the DUT.
    // ------------------------------------------------------------------
    logic [DW-1:0] fmem [0:255];
    int  wr_ptr   = 0;
    int  rd_ptr   = 0;
    int  rd_count = 0;   // every fifo_read pulse seen
    int  rd_viol  = 0;   // fifo_read while empty
    logic fifo_flush = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_read) begin
            rd_count <= rd_count + 1;
            if (fifo_empty) rd_viol <= rd_viol + 1;
            else begin
                fifo_data <= fmem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            exp_idx = 0;   // position of next expected word in packet
    int            cyc = 0;
    int            hs_count = 0;
    int            first_hs = -1;
    int            last_hs = -1;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic          held_last = 1'b0;

    task automatic push_word(input logic [DW-1:0] d, input bit expect_it);
        exp_t e;
        fmem[wr_ptr] = d;
        wr_ptr++;
        if (expect_it) begin
            e.data = d;
            e.last = (exp_idx == PL - 1);
            exp_idx = (exp_idx + 1) % PL;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: check the stream at the falling edge, then return
    // just after the next rising edge so the caller can drive inputs.
    task automatic tick();
        exp_t e;
        logic want_par;
        @(negedge clk);
        if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         out_valid, out_data, out_last, held_data, held_last);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_count++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h last=%b, required no word", out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_last !== e.last) begin
                    errors++;
                    $display("FAIL word: got data=%h last=%b, required data=%h last=%b",
                             out_data, out_last, e.data, e.last);
                end
`ifdef FIFO_READER_PARITY_EN
                want_par = ^e.data;
                checks++;
                if (out_parity !== want_par) begin
                    errors++;
                    $display("FAIL parity: data=%h got parity=%b, required %b", e.data, out_parity, want_par);
                end
`else
                want_par = 1'b0;
`endif
            end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        held_data  = out_data;
        held_last  = out_last;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic flush_fifo();
        fifo_flush = 1'b1;
        tick();
        fifo_flush = 1'b0;
    endtask

    task automatic check_idle(input string name);
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b out_valid=%b, required 0 0", name, busy, out_valid);
        end
        checks++;
        if (rd_viol !== 0) begin
            errors++;
            $display("FAIL %s_read_empty: %0d reads while empty, required 0", name, rd_viol);
        end
    endtask

    task automatic clear_hs();
        hs_count = 0;
        first_hs = -1;
        last_hs  = -1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        push_word(8'h5A, 1'b0);  // FIFO non-empty while in reset
        for (int i = 0; i < 16; i++) begin
            en        = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (fifo_read !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
                out_last !== 1'b0 || pkt_count !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: rd=%b v=%b d=%h l=%b pc=%0d busy=%b, required all 0",
                         fifo_read, out_valid, out_data, out_last, pkt_count, busy);
            end
        end
        checks++;
        if (rd_count !== 0) begin
            errors++;
            $display("FAIL reset_no_read: %0d reads, required 0", rd_count);
        end
        en = 1'b0;
        out_ready = 1'b0;
        flush_fifo();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int pkt0, en_cyc;
        pkt0 = pkt_count;
        clear_hs();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(8'(i * 8'h11), 1'b1);
        en = 1'b1;
        en_cyc = cyc;
        wait_drain(40, "b2b");
        checks++;
        if (hs_count !== 8 || last_hs - first_hs !== 7) begin
            errors++;
            $display("FAIL b2b_rate: %0d words over %0d cycles, required 8 over 7", hs_count, last_hs - first_hs);
        end
        // en seen at edge+1 -> RUN, edge+2 word in flight, edge+3 buffered,
        // so the first handshake is sampled three cycles after en.
        checks++;
        if (first_hs - en_cyc !== 3) begin
            errors++;
            $display("FAIL b2b_latency: first word %0d cycles after en, required 3", first_hs - en_cyc);
        end
        checks++;
        if (pkt_count !== CW'(pkt0 + 2)) begin
            errors++;
            $display("FAIL b2b_pkt_count: got %0d, required %0d", pkt_count, pkt0 + 2);
        end
        en = 1'b0;
        check_idle("b2b");
    endtask

    task automatic test_stall_toggle();
        int pkt0, n;
        pkt0 = pkt_count;
        clear_hs();
        for (int i = 1; i <= 8; i++) push_word(8'(i * 8'h11), 1'b1);
        en = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            out_ready = ~out_ready;
            tick();
            n++;
        end
        wait_drain(1, "toggle");
        checks++;
        if (hs_count !== 8 || pkt_count !== CW'(pkt0 + 2)) begin
            errors++;
            $display("FAIL toggle_count: words=%0d pkts=%0d, required 8 and %0d", hs_count, pkt_count, pkt0 + 2);
        end
        en = 1'b0;
        out_ready = 1'b1;
        check_idle("toggle");
    endtask

    task automatic test_en_drop();
        int pkt0, r0, n;
        pkt0 = pkt_count;
        r0 = rd_count;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(8'(i * 8'h11), i <= 4);
        en = 1'b1;
        n = 0;
        while (rd_count - r0 < 2 && n < 20) begin
            tick();
            n++;
        end
        en = 1'b0;
        repeat (20) tick();
        wait_drain(1, "endrop");
        checks++;
        if (rd_count - r0 !== 4 || wr_ptr - rd_ptr !== 4) begin
            errors++;
            $display("FAIL endrop_reads: read %0d, left %0d, required 4 and 4", rd_count - r0, wr_ptr - rd_ptr);
        end
        checks++;
        if (pkt_count !== CW'(pkt0 + 1)) begin
            errors++;
            $display("FAIL endrop_pkt_count: got %0d, required %0d", pkt_count, pkt0 + 1);
        end
        check_idle("endrop");
        flush_fifo();
    endtask

    task automatic test_empty_stall();
        int pkt0;
        pkt0 = pkt_count;
        out_ready = 1'b1;
        push_word(8'hA1, 1'b1);
        push_word(8'hA2, 1'b1);
        en = 1'b1;
        wait_drain(20, "empty_head");
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (fifo_read !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL empty_stall: rd=%b valid=%b last=%b, required 0 0 0", fifo_read, out_valid, out_last);
            end
        end
        push_word(8'hD1, 1'b1);
        push_word(8'hD2, 1'b1);  // expected last: completes the packet
        wait_drain(20, "empty_tail");
        checks++;
        if (pkt_count !== CW'(pkt0 + 1)) begin
            errors++;
            $display("FAIL empty_pkt_count: got %0d, required %0d", pkt_count, pkt0 + 1);
        end
        en = 1'b0;
        check_idle("empty");
    endtask

    task automatic test_reset_mid();
        int n;
        clear_hs();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(8'(8'h30 + i), 1'b1);
        en = 1'b1;
        n = 0;
        while (hs_count < 2 && n < 20) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_read !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_last !== 1'b0 || pkt_count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: rd=%b v=%b d=%h l=%b pc=%0d busy=%b, required all 0",
                     fifo_read, out_valid, out_data, out_last, pkt_count, busy);
        end
        exp_q.delete();
        exp_idx = 0;
        prev_stall = 1'b0;
        flush_fifo();
        tick();
        rst_n = 1'b1;
        // New packet must restart at word 0; 8'h07 has odd parity.
        push_word(8'h07, 1'b1);
        push_word(8'h5A, 1'b1);
        push_word(8'h13, 1'b1);
        push_word(8'h3C, 1'b1);
        wait_drain(30, "midreset");
        checks++;
        if (pkt_count !== CW'(1)) begin
            errors++;
            $display("FAIL midreset_pkt_count: got %0d, required 1", pkt_count);
        end
        en = 1'b0;
        check_idle("midreset");
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_stall_toggle();
        test_en_drop();
        test_empty_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
